// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and helpers for the shift register controller.
package shift_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  // A length of zero or one larger than the word means "send the whole word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Upstream word handshake and downstream serial-bit handshake.
interface shift_reg_ctrl_if
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;

  // Producer of words / consumer of bits.
  modport master (
    output in_valid, in_data, in_len, ser_ready,
    input  in_ready, ser_out, ser_valid
  );

  // The controller side.
  modport slave (
    input  in_valid, in_data, in_len, ser_ready,
    output in_ready, ser_out, ser_valid
  );

endinterface

// File: rtl/shift_bit_counter.sv
// Counts accepted serial bits of the current frame and flags the final one.
module shift_bit_counter #(
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             last
);

  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W:0]   count_inc;

  // Next count: clear wins, saturate instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // One extra bit so the compare is exact when len equals the maximum count.
  assign count_inc = {1'b0, count_q} + {{LEN_W{1'b0}}, 1'b1};
  assign last      = (count_inc == {1'b0, len});

endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequences an external left shift register to send words MSB-first as a bit stream.
module shift_reg_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  shift_reg_ctrl_if.slave  bus,
  output logic             sr_clr,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_shift_en,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             bit_last;

  assign accept = (state_q == StIdle) && bus.in_valid;

  // State register; reset lands in StClear so the register gets a sync clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: state_d = StIdle;
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (sr_shift_en && bit_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StClear;
    endcase
  end

  // Capture the word and its effective length on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      len_q  <= '0;
    end else if (accept) begin
      data_q <= bus.in_data;
      len_q  <= LEN_W'(clamp_len(32'(bus.in_len), WIDTH));
    end
  end

  shift_bit_counter #(
    .LEN_W (LEN_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (sr_load),
    .inc  (sr_shift_en),
    .len  (len_q),
    .last (bit_last)
  );

  // Output decode from state plus downstream ready.
  always_comb begin
    sr_clr        = 1'b0;
    sr_load       = 1'b0;
    sr_d          = '0;
    sr_shift_en   = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_out   = sr_q[WIDTH-1];
    busy          = (state_q != StIdle);
    done          = 1'b0;
    unique case (state_q)
      StClear: sr_clr = 1'b1;
      StIdle:  bus.in_ready = 1'b1;
      StLoad: begin
        sr_load = 1'b1;
        sr_d    = data_q;
      end
      StShift: begin
        bus.ser_valid = 1'b1;
        sr_shift_en   = bus.ser_ready;
      end
      StDone:  done = 1'b1;
      default: sr_clr = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomised bench for shift_reg_ctrl with a behavioural shift register and reference model.
module tb_shift_reg_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sr_clr, sr_load, sr_shift_en, busy, done;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_q = '0;

  shift_reg_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  shift_reg_ctrl #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sr_clr      (sr_clr),
    .sr_load     (sr_load),
    .sr_d        (sr_d),
    .sr_shift_en (sr_shift_en),
    .sr_q        (sr_q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // The controlled 4-bit register: sync clear, parallel load, shift left with zero fill.
  always @(posedge clk) begin
    if (sr_clr) sr_q <= '0;
    else if (sr_load) sr_q <= sr_d;
    else if (sr_shift_en) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  int rdy_mode = 0;
  initial begin
    bus.ser_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
  end
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.ser_ready = 1'b1;
    else if (rdy_mode == 1) bus.ser_ready = ($urandom_range(0, 3) != 0);
    else bus.ser_ready = 1'b0;
  end

  // Reference model: frame timeline measured from the acceptance cycle plus a queue of bits due.
  bit             m_active = 1'b0;
  bit             m_clear = 1'b1;
  int             m_acc = 0;
  int             m_left = 0;
  int             m_done_due = -10;
  logic [WIDTH-1:0] m_word = '0;
  bit             m_q[$];
  bit             got[$];
  int             acc_cyc[$];
  int             done_cnt = 0;
  bit             e_idle, e_load, e_valid, e_done;
  int             m_len;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_sr_clr", sr_clr, 1);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_busy", busy, 1);
      check("rst_sr_load", sr_load, 0);
      check("rst_sr_d", sr_d, 0);
      check("rst_shift_en", sr_shift_en, 0);
      check("rst_ser_valid", bus.ser_valid, 0);
      check("rst_done", done, 0);
      m_active = 1'b0;
      m_left = 0;
      m_q.delete();
      m_clear = 1'b1;
      m_done_due = -10;
    end else begin
      e_idle  = !m_active && !m_clear;
      e_load  = m_active && (cyc == m_acc + 1);
      e_valid = m_active && (cyc >= m_acc + 2) && (m_left > 0);
      e_done  = m_active && (m_left == 0) && (cyc == m_done_due);
      check("sr_clr", sr_clr, m_clear);
      check("in_ready", bus.in_ready, e_idle);
      check("busy", busy, !e_idle);
      check("sr_load", sr_load, e_load);
      check("ser_valid", bus.ser_valid, e_valid);
      check("sr_shift_en", sr_shift_en, e_valid && bus.ser_ready);
      check("done", done, e_done);
      check("ser_out_is_msb", bus.ser_out, sr_q[WIDTH-1]);
      check("load_shift_excl", sr_load && sr_shift_en, 0);
      check("clr_excl", sr_clr && (sr_load || sr_shift_en), 0);
      if (e_load) check("sr_d", sr_d, m_word);
      if (e_valid && m_q.size() > 0) check("ser_out", bus.ser_out, m_q[0]);
      if (done) done_cnt++;
      if (e_valid && bus.ser_ready) begin
        got.push_back(bus.ser_out);
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_left--;
        if (m_left == 0) m_done_due = cyc + 1;
      end
      if (e_done) m_active = 1'b0;
      m_clear = 1'b0;
      if (e_idle && bus.in_valid) begin
        m_len = int'(bus.in_len);
        if (m_len == 0 || m_len > int'(WIDTH)) m_len = WIDTH;
        m_word = bus.in_data;
        for (int i = 0; i < m_len; i++) m_q.push_back(bus.in_data[WIDTH-1-i]);
        m_left = m_len;
        m_acc = cyc;
        m_active = 1'b1;
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Present a word starting just after a rising edge; returns the acceptance cycle.
  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l, input bit hold,
                      output int acc);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (bus.in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail("accept");
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (done) return;
    end
    fail("wait_done");
  endtask

  task automatic wait_bits(input int n);
    for (int k = 0; k < 200; k++) begin
      if (got.size() >= n) return;
      @(negedge clk); #1;
    end
    fail("wait_bits");
  endtask

  task automatic check_stream(input string name, input int start, input int n,
                              input logic [7:0] pat);
    check({name, "_len"}, got.size() - start, n);
    for (int i = 0; i < n; i++)
      if (start + i < got.size()) check(name, got[start+i], pat[n-1-i]);
  endtask

  int a1, a2, st, n_sent, d0;
  logic [WIDTH-1:0] rd;
  logic [LEN_W-1:0] rl;

  initial begin
    n_sent = 0;
    // Reset held three cycles.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("t1_clr", sr_clr, 1);
    check("t1_in_ready", bus.in_ready, 0);
    check("t1_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("t1_clear_cycle", sr_clr, 1);
    @(negedge clk); #1;
    check("t1_clr_off", sr_clr, 0);
    check("t1_ready_on", bus.in_ready, 1);

    // Full-length word, literal timeline.
    send(4'b1011, 3'd4, 1'b0, a1); n_sent++;
    @(negedge clk); #1;
    check("t2_load", sr_load, 1);
    check("t2_d", sr_d, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("t2_bit", bus.ser_out, (i == 1) ? 0 : 1);
      check("t2_shift_en", sr_shift_en, 1);
    end
    @(negedge clk); #1;
    check("t2_done", done, 1);
    @(negedge clk); #1;
    check("t2_ready", bus.in_ready, 1);

    // Short length and zero length.
    st = got.size();
    send(4'b0111, 3'd2, 1'b0, a1); n_sent++;
    wait_done();
    check_stream("t3_len2", st, 2, 8'b01);
    st = got.size();
    send(4'b1100, 3'd0, 1'b0, a1); n_sent++;
    wait_done();
    check_stream("t3_len0", st, 4, 8'b1100);

    // Downstream stall after the second bit.
    st = got.size();
    d0 = done_cnt;
    send(4'b1001, 3'd4, 1'b0, a1); n_sent++;
    wait_bits(st + 2);
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t4_hold_out", bus.ser_out, 0);
      check("t4_hold_shift", sr_shift_en, 0);
      check("t4_hold_valid", bus.ser_valid, 1);
    end
    rdy_mode = 0;
    wait_done();
    check_stream("t4_stream", st, 4, 8'b1001);
    check("t4_one_done", done_cnt - d0, 1);

    // Back-to-back words with in_valid held.
    st = got.size();
    send(4'b1111, 3'd4, 1'b1, a1); n_sent++;
    send(4'b0001, 3'd4, 1'b0, a2); n_sent++;
    check("t5_spacing", a2 - a1, 7);
    wait_done();
    check_stream("t5_stream", st, 8, 8'b11110001);

    // Asynchronous reset mid-frame.
    st = got.size();
    send(4'b0110, 3'd4, 1'b0, a1);
    wait_bits(st + 2);
    @(posedge clk); #3;
    rst = 1'b0;
    d0 = done_cnt;
    #1;
    check("t6_clr", sr_clr, 1);
    check("t6_in_ready", bus.in_ready, 0);
    check("t6_busy", busy, 1);
    check("t6_valid", bus.ser_valid, 0);
    check("t6_shift", sr_shift_en, 0);
    check("t6_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("t6_clear_cycle", sr_clr, 1);
    @(negedge clk); #1;
    check("t6_clr_off", sr_clr, 0);
    check("t6_ready", bus.in_ready, 1);
    check("t6_no_done", done_cnt, d0);
    st = got.size();
    send(4'b1010, 3'd4, 1'b0, a1); n_sent++;
    wait_done();
    check_stream("t6_stream", st, 4, 8'b1010);

    // Random words, lengths and downstream backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 25; n++) begin
      rd = WIDTH'($urandom);
      rl = LEN_W'($urandom_range(0, 7));
      send(rd, rl, 1'b0, a1); n_sent++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 0;
    wait_done();
    @(negedge clk); #1;
    check("final_idle", bus.in_ready, 1);
    check("final_done_count", done_cnt, n_sent);
    check("final_queue_empty", m_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
